// File: rtl/lsq_retire_unit_pkg.sv
// rtl/lsq_retire_unit_pkg.sv - shared types and constants for the LSQ retire unit
package lsu_pkg;

    localparam int THREADS    = 4;
    localparam int WARP_W     = 2;
    localparam int REG_W      = 4;
    localparam int ADDR_LANES = 8;
    localparam int LSU_DATA_W = 16;
    localparam int LSU_ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_RD,
        LOAD_WB,
        STORE_WR,
        DONE
    } retire_state_t;

    // Buffered request; only lanes 0..THREADS-1 of addr are ever used.
    typedef struct packed {
        logic                                   instr_bit;
        logic [WARP_W-1:0]                      warp;
        logic [REG_W-1:0]                       dest_reg;
        logic [ADDR_LANES-1:0][LSU_ADDR_W-1:0]  addr;
        logic [THREADS-1:0]                     mask;
        logic [LSU_DATA_W-1:0]                  data;
    } lsu_req_t;

endpackage

// File: rtl/lsq_retire_unit_if.sv
// rtl/lsq_retire_unit_if.sv - request, data-memory, register-file and done signals
interface lsq_retire_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    import lsu_pkg::*;

    logic                    in_valid;
    logic                    in_instr_bit;
    logic [WARP_W-1:0]       in_warp;
    logic [REG_W-1:0]        in_dest_reg;
    logic [8*ADDR_WIDTH-1:0] in_addr;
    logic [THREADS-1:0]      in_mask;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    fifo_full;
    logic                    overflow;
    logic                    dmem_re;
    logic                    dmem_we;
    logic [ADDR_WIDTH-1:0]   dmem_addr;
    logic [DATA_WIDTH-1:0]   dmem_wdata;
    logic [DATA_WIDTH-1:0]   dmem_rdata;
    logic                    rf_we;
    logic [WARP_W-1:0]       rf_warp;
    logic [1:0]              rf_thread;
    logic [REG_W-1:0]        rf_reg;
    logic [DATA_WIDTH-1:0]   rf_wdata;
    logic                    done_valid;
    logic [WARP_W-1:0]       done_warp;
    logic                    done_is_store;

    modport master (
        output in_valid, in_instr_bit, in_warp, in_dest_reg, in_addr, in_mask, in_data,
        output dmem_rdata,
        input  fifo_full, overflow, dmem_re, dmem_we, dmem_addr, dmem_wdata,
        input  rf_we, rf_warp, rf_thread, rf_reg, rf_wdata,
        input  done_valid, done_warp, done_is_store
    );

    modport slave (
        input  in_valid, in_instr_bit, in_warp, in_dest_reg, in_addr, in_mask, in_data,
        input  dmem_rdata,
        output fifo_full, overflow, dmem_re, dmem_we, dmem_addr, dmem_wdata,
        output rf_we, rf_warp, rf_thread, rf_reg, rf_wdata,
        output done_valid, done_warp, done_is_store
    );

endinterface

// File: rtl/lsu_req_fifo.sv
// rtl/lsu_req_fifo.sv - synchronous request FIFO with extra-MSB wrap pointers
module lsu_req_fifo
    import lsu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  lsu_req_t                      push_data,
    input  logic                          pop,
    output lsu_req_t                      head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    lsu_req_t    mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/lsq_retire_unit.sv
// rtl/lsq_retire_unit.sv - retires LSQ requests lane by lane into dmem / register file
module lsq_retire_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    lsq_retire_unit_if.slave   bus
);
    lsu_req_t                          in_req;
    lsu_req_t                          head;
    logic                              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]       fifo_count;
    logic [THREADS-1:0][ADDR_WIDTH-1:0] head_lo;
    logic                              unused_ok;

    retire_state_t                      state_q, state_d;
    logic [WARP_W-1:0]                  warp_q, warp_d;
    logic [REG_W-1:0]                   dest_q, dest_d;
    logic [THREADS-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [THREADS-1:0]                 mask_q, mask_d;
    logic [DATA_WIDTH-1:0]              data_q, data_d;
    logic [1:0]                         lane_q, lane_d;
    logic                               overflow_q, overflow_d;

    logic                    dmem_re_q, dmem_re_d, dmem_we_q, dmem_we_d;
    logic [ADDR_WIDTH-1:0]   dmem_addr_q, dmem_addr_d;
    logic [DATA_WIDTH-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic                    rf_we_q, rf_we_d;
    logic [WARP_W-1:0]       rf_warp_q, rf_warp_d;
    logic [1:0]              rf_thread_q, rf_thread_d;
    logic [REG_W-1:0]        rf_reg_q, rf_reg_d;
    logic                    done_valid_q, done_valid_d;
    logic [WARP_W-1:0]       done_warp_q, done_warp_d;
    logic                    done_is_store_q, done_is_store_d;

    logic [THREADS-1:0] mask_rem;
    logic [1:0]         first_lane, next_lane;

    function automatic logic [1:0] lowest_lane(input logic [THREADS-1:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        in_req           = '0;
        in_req.instr_bit = bus.in_instr_bit;
        in_req.warp      = bus.in_warp;
        in_req.dest_reg  = bus.in_dest_reg;
        in_req.addr      = bus.in_addr;
        in_req.mask      = bus.in_mask;
        in_req.data      = bus.in_data;
    end

    // A full FIFO still takes a push when IDLE pops in the same cycle.
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
    assign fifo_push = bus.in_valid && (!fifo_full || fifo_pop);

    lsu_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (in_req),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_lo    = head.addr[THREADS-1:0];
    assign unused_ok  = ^{head.addr[ADDR_LANES-1:THREADS], fifo_count};
    assign first_lane = lowest_lane(head.mask);
    assign mask_rem   = mask_q & ~(4'b0001 << lane_q);
    assign next_lane  = lowest_lane(mask_rem);

    // Outputs are registered: each transition loads the strobes of the state being entered.
    always_comb begin
        state_d         = state_q;
        warp_d          = warp_q;
        dest_d          = dest_q;
        addr_d          = addr_q;
        mask_d          = mask_q;
        data_d          = data_q;
        lane_d          = lane_q;
        overflow_d      = overflow_q | (bus.in_valid & ~fifo_push);
        dmem_re_d       = 1'b0;
        dmem_we_d       = 1'b0;
        dmem_addr_d     = '0;
        dmem_wdata_d    = '0;
        rf_we_d         = 1'b0;
        rf_warp_d       = '0;
        rf_thread_d     = '0;
        rf_reg_d        = '0;
        done_valid_d    = 1'b0;
        done_warp_d     = '0;
        done_is_store_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    warp_d = head.warp;
                    dest_d = head.dest_reg;
                    addr_d = head_lo;
                    mask_d = head.mask;
                    data_d = head.data;
                    lane_d = first_lane;
                    if (head.mask == '0) begin
                        state_d         = DONE;
                        done_valid_d    = 1'b1;
                        done_warp_d     = head.warp;
                        done_is_store_d = head.instr_bit;
                    end else if (!head.instr_bit) begin
                        state_d     = LOAD_RD;
                        dmem_re_d   = 1'b1;
                        dmem_addr_d = head_lo[first_lane];
                    end else begin
                        state_d      = STORE_WR;
                        dmem_we_d    = 1'b1;
                        dmem_addr_d  = head_lo[first_lane];
                        dmem_wdata_d = head.data;
                    end
                end
            end
            LOAD_RD: begin
                state_d     = LOAD_WB;
                rf_we_d     = 1'b1;
                rf_warp_d   = warp_q;
                rf_thread_d = lane_q;
                rf_reg_d    = dest_q;
            end
            LOAD_WB: begin
                mask_d = mask_rem;
                if (mask_rem != '0) begin
                    state_d     = LOAD_RD;
                    lane_d      = next_lane;
                    dmem_re_d   = 1'b1;
                    dmem_addr_d = addr_q[next_lane];
                end else begin
                    state_d      = DONE;
                    done_valid_d = 1'b1;
                    done_warp_d  = warp_q;
                end
            end
            STORE_WR: begin
                mask_d = mask_rem;
                if (mask_rem != '0) begin
                    lane_d       = next_lane;
                    dmem_we_d    = 1'b1;
                    dmem_addr_d  = addr_q[next_lane];
                    dmem_wdata_d = data_q;
                end else begin
                    state_d         = DONE;
                    done_valid_d    = 1'b1;
                    done_warp_d     = warp_q;
                    done_is_store_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            warp_q          <= '0;
            dest_q          <= '0;
            addr_q          <= '0;
            mask_q          <= '0;
            data_q          <= '0;
            lane_q          <= '0;
            overflow_q      <= 1'b0;
            dmem_re_q       <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= '0;
            dmem_wdata_q    <= '0;
            rf_we_q         <= 1'b0;
            rf_warp_q       <= '0;
            rf_thread_q     <= '0;
            rf_reg_q        <= '0;
            done_valid_q    <= 1'b0;
            done_warp_q     <= '0;
            done_is_store_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            warp_q          <= warp_d;
            dest_q          <= dest_d;
            addr_q          <= addr_d;
            mask_q          <= mask_d;
            data_q          <= data_d;
            lane_q          <= lane_d;
            overflow_q      <= overflow_d;
            dmem_re_q       <= dmem_re_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_wdata_q    <= dmem_wdata_d;
            rf_we_q         <= rf_we_d;
            rf_warp_q       <= rf_warp_d;
            rf_thread_q     <= rf_thread_d;
            rf_reg_q        <= rf_reg_d;
            done_valid_q    <= done_valid_d;
            done_warp_q     <= done_warp_d;
            done_is_store_q <= done_is_store_d;
        end
    end

    assign bus.fifo_full     = fifo_full;
    assign bus.overflow      = overflow_q;
    assign bus.dmem_re       = dmem_re_q;
    assign bus.dmem_we       = dmem_we_q;
    assign bus.dmem_addr     = dmem_addr_q;
    assign bus.dmem_wdata    = dmem_wdata_q;
    assign bus.rf_we         = rf_we_q;
    assign bus.rf_warp       = rf_warp_q;
    assign bus.rf_thread     = rf_thread_q;
    assign bus.rf_reg        = rf_reg_q;
    // Read data lands in the write-back cycle, so it is forwarded rather than registered.
    assign bus.rf_wdata      = rf_we_q ? bus.dmem_rdata : '0;
    assign bus.done_valid    = done_valid_q;
    assign bus.done_warp     = done_warp_q;
    assign bus.done_is_store = done_is_store_q;

endmodule

// File: tb/tb_lsq_retire_unit.sv
// tb/tb_lsq_retire_unit.sv - scoreboard bench for lsq_retire_unit
module tb_lsq_retire_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsq_retire_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    lsq_retire_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Entries: [63:32] expected cycle (0 = untimed), low bits = expected fields.
    logic [63:0] exp_rd[$];
    logic [63:0] exp_rf[$];
    logic [63:0] exp_wr[$];
    logic [63:0] exp_done[$];
    logic [63:0] mon_e;

    bit [15:0] mem [256];
    bit        wmask [256];

    bit ovf_full_exp [6] = '{0, 0, 0, 0, 1, 1};
    bit ovf_flag_exp [6] = '{0, 0, 0, 0, 0, 1};

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h1A) ? 16'hBEEF : (16'hA000 + {8'h00, a});
    endfunction

    always @(posedge clk) begin
        if (bus.dmem_we === 1'b1) begin
            mem[bus.dmem_addr]   <= bus.dmem_wdata;
            wmask[bus.dmem_addr] <= 1'b1;
        end
        if (bus.dmem_re === 1'b1)
            bus.dmem_rdata <= wmask[bus.dmem_addr] ? mem[bus.dmem_addr] : init_val(bus.dmem_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got an unexpected strobe, expected none (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (bus.dmem_re === 1'b1) begin
            if (exp_rd.size() == 0) unexpected("dmem_re");
            else begin
                mon_e = exp_rd.pop_front();
                chk("rd_addr", 64'(bus.dmem_addr), 64'(mon_e[7:0]));
                if (mon_e[63:32] != 0) chk("rd_cycle", 64'(cyc), 64'(mon_e[63:32]));
            end
        end
        if (bus.dmem_we === 1'b1) begin
            if (exp_wr.size() == 0) unexpected("dmem_we");
            else begin
                mon_e = exp_wr.pop_front();
                chk("wr_addr_data", 64'({bus.dmem_addr, bus.dmem_wdata}), 64'(mon_e[23:0]));
                if (mon_e[63:32] != 0) chk("wr_cycle", 64'(cyc), 64'(mon_e[63:32]));
            end
        end
        if (bus.rf_we === 1'b1) begin
            if (exp_rf.size() == 0) unexpected("rf_we");
            else begin
                mon_e = exp_rf.pop_front();
                chk("rf_write", 64'({bus.rf_warp, bus.rf_thread, bus.rf_reg, bus.rf_wdata}),
                    64'(mon_e[23:0]));
                if (mon_e[63:32] != 0) chk("rf_cycle", 64'(cyc), 64'(mon_e[63:32]));
            end
        end
        if (bus.done_valid === 1'b1) begin
            if (exp_done.size() == 0) unexpected("done_valid");
            else begin
                mon_e = exp_done.pop_front();
                chk("done_fields", 64'({bus.done_warp, bus.done_is_store}), 64'(mon_e[2:0]));
                if (mon_e[63:32] != 0) chk("done_cycle", 64'(cyc), 64'(mon_e[63:32]));
            end
        end
    end

    task automatic idle_in();
        bus.in_valid     = 1'b0;
        bus.in_instr_bit = 1'b0;
        bus.in_warp      = '0;
        bus.in_dest_reg  = '0;
        bus.in_addr      = '0;
        bus.in_mask      = '0;
        bus.in_data      = '0;
    endtask

    task automatic drive(input logic st, input logic [1:0] w, input logic [3:0] d,
                         input logic [31:0] a4, input logic [3:0] m, input logic [15:0] data);
        bus.in_valid     = 1'b1;
        bus.in_instr_bit = st;
        bus.in_warp      = w;
        bus.in_dest_reg  = d;
        bus.in_addr      = {32'hDEADBEEF, a4};
        bus.in_mask      = m;
        bus.in_data      = data;
    endtask

    // Ascending lanes; load lane k reads at E+1+2k, writes back at E+2+2k; store lane k at E+1+k.
    task automatic expect_req(input logic st, input logic [1:0] w, input logic [3:0] d,
                              input logic [31:0] a4, input logic [3:0] m, input logic [15:0] data,
                              input int e_cap, input bit timed);
        int k;
        int lat;
        logic [7:0] a;
        k = 0;
        for (int l = 0; l < 4; l++) begin
            if (m[l]) begin
                a = a4[l*8 +: 8];
                if (!st) begin
                    exp_rd.push_back({timed ? 32'(e_cap + 1 + 2*k) : 32'd0, 24'h0, a});
                    exp_rf.push_back({timed ? 32'(e_cap + 2 + 2*k) : 32'd0, 8'h0,
                                      w, 2'(l), d, init_val(a)});
                end else begin
                    exp_wr.push_back({timed ? 32'(e_cap + 1 + k) : 32'd0, 8'h0, a, data});
                end
                k++;
            end
        end
        lat = st ? (1 + k) : (1 + 2*k);
        exp_done.push_back({timed ? 32'(e_cap + lat) : 32'd0, 29'h0, w, st});
    endtask

    task automatic issue(input logic st, input logic [1:0] w, input logic [3:0] d,
                         input logic [31:0] a4, input logic [3:0] m, input logic [15:0] data);
        drive(st, w, d, a4, m, data);
        expect_req(st, w, d, a4, m, data, cyc + 1, 1'b1);
        @(negedge clk);
        idle_in();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_rd.size() + exp_rf.size() + exp_wr.size() + exp_done.size()) != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("drain_pending", 64'(exp_rd.size() + exp_rf.size() + exp_wr.size() + exp_done.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, 64'({bus.dmem_re, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata,
                       bus.rf_we, bus.rf_warp, bus.rf_thread, bus.rf_reg, bus.rf_wdata,
                       bus.done_valid, bus.done_warp, bus.done_is_store,
                       bus.fifo_full, bus.overflow}), 64'd0);
    endtask

    initial begin
        int e0;
        logic [31:0] a4;
        idle_in();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        chk("reset_fifo_empty", 64'(dut.fifo_empty), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        // Single-lane load: warp 2, lane 2, reg 5, mem[0x1A]=0xBEEF, done at E+3.
        issue(1'b0, 2'd2, 4'd5, 32'h001A0000, 4'b0100, 16'h0000);
        drain(40);

        // Full-mask store of 0x1234 to 0x10..0x13, done at E+5.
        issue(1'b1, 2'd1, 4'd0, 32'h13121110, 4'b1111, 16'h1234);
        drain(40);

        // Empty mask: done only, at E+1.
        issue(1'b0, 2'd3, 4'd7, 32'h55555555, 4'b0000, 16'h0000);
        drain(40);
        chk("idle_full", 64'(bus.fifo_full), 64'd0);

        // Fill the FIFO behind a long load, then push in the IDLE cycle that pops.
        e0 = cyc + 1;
        drive(1'b0, 2'd0, 4'd1, 32'h23222120, 4'b1111, 16'h0);
        expect_req(1'b0, 2'd0, 4'd1, 32'h23222120, 4'b1111, 16'h0, e0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive(1'(i % 2 == 0), 2'(i), 4'd0, 32'h0, 4'b0000, 16'h0);
            expect_req(1'(i % 2 == 0), 2'(i), 4'd0, 32'h0, 4'b0000, 16'h0, 0, 1'b0);
        end
        @(negedge clk);
        idle_in();
        chk("full_after_fill", 64'(bus.fifo_full), 64'd1);
        while (cyc < e0 + 10) @(negedge clk);
        chk("full_before_simul", 64'(bus.fifo_full), 64'd1);
        drive(1'b0, 2'd2, 4'd0, 32'h0, 4'b0000, 16'h0);
        expect_req(1'b0, 2'd2, 4'd0, 32'h0, 4'b0000, 16'h0, 0, 1'b0);
        @(negedge clk);
        idle_in();
        chk("full_after_simul", 64'(bus.fifo_full), 64'd1);
        chk("simul_no_overflow", 64'(bus.overflow), 64'd0);
        chk("simul_count", 64'(dut.u_fifo.count), 64'd4);
        drain(100);

        // Six back-to-back full-mask loads: the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            a4 = {8'(67 + 4*i), 8'(66 + 4*i), 8'(65 + 4*i), 8'(64 + 4*i)};
            drive(1'b0, 2'(i), 4'(i + 1), a4, 4'b1111, 16'h0);
            if (i < 5) expect_req(1'b0, 2'(i), 4'(i + 1), a4, 4'b1111, 16'h0, 0, 1'b0);
            @(negedge clk);
            chk($sformatf("ovf_full_%0d", i), 64'(bus.fifo_full), 64'(ovf_full_exp[i]));
            chk($sformatf("ovf_flag_%0d", i), 64'(bus.overflow), 64'(ovf_flag_exp[i]));
        end
        idle_in();
        drain(200);
        chk("overflow_sticky", 64'(bus.overflow), 64'd1);

        // Reset during LOAD_WB of lane 1 of a mask-0011 load.
        issue(1'b0, 2'd1, 4'd3, 32'h00006160, 4'b0011, 16'h0);
        void'(exp_done.pop_back());
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("midload_reset_outputs");
        chk("midload_fifo_empty", 64'(dut.fifo_empty), 64'd1);
        reset = 1'b0;
        drain(10);

        // Following load, lanes 1 and 3, done at E+5.
        issue(1'b0, 2'd3, 4'd9, 32'h73727170, 4'b1010, 16'h0);
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion within 200000 time units");
        $fatal(1);
    end

endmodule
